qspi_flash_sequencer: RTL and testbench

Command-level front end for the QSPI byte controller: accepts one flash operation per request (opcode, 24-bit address, length), breaks it into a sequence of byte transfers (command, address, dummy, data) and drives the byte controller's valid/ready interface with the correct direction and wire width per phase. It sits directly upstream of the byte controller and downstream of the crypto core's memory client, which sees a simple request/write-stream/read-stream interface.

---
 rtl/qspi_pkg.sv | 40 ++++
 rtl/qspi_flash_sequencer_if.sv | 35 +++
 rtl/qspi_flash_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_qspi_flash_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared constants and types for the QSPI flash command sequencer.
// Holds wire-width codes, flash opcodes, request op encoding and FSM states.
package qspi_pkg;

    localparam logic [1:0] WIREWIDTH_1 = 2'b00;
    localparam logic [1:0] WIREWIDTH_2 = 2'b01;
    localparam logic [1:0] WIREWIDTH_4 = 2'b11;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_QUAD_READ = 8'h6B;
    localparam logic [7:0] OPC_PAGE_PROG = 8'h02;
    localparam logic [7:0] OPC_WREN      = 8'h06;

    typedef enum logic [1:0] {
        OP_READ      = 2'b00,
        OP_QUAD_READ = 2'b01,
        OP_PAGE_PROG = 2'b10,
        OP_WREN      = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP,
        ST_DONE
    } state_e;

    function automatic logic [7:0] op_opcode(input op_e op);
        case (op)
            OP_READ:      return OPC_READ;
            OP_QUAD_READ: return OPC_QUAD_READ;
            OP_PAGE_PROG: return OPC_PAGE_PROG;
            default:      return OPC_WREN;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_sequencer_if.sv
// Request/stream side and byte-controller side of the flash sequencer.
// master = sequencer, slave = memory client plus byte controller.
interface qspi_flash_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic [7:0]  wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic [7:0]  byte_tx;
    logic [7:0]  byte_rx;
    logic        byte_r_w;
    logic [1:0]  byte_width;
    logic        byte_valid;
    logic        byte_ready;

    modport master (
        input  req_valid, req_op, req_addr, req_len, wdata, wdata_valid, byte_rx, byte_ready,
        output req_ready, wdata_ready, rdata, rdata_valid, done, err, busy,
               byte_tx, byte_r_w, byte_width, byte_valid
    );

    modport slave (
        output req_valid, req_op, req_addr, req_len, wdata, wdata_valid, byte_rx, byte_ready,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, err, busy,
               byte_tx, byte_r_w, byte_width, byte_valid
    );
endinterface

// File: rtl/qspi_flash_sequencer.sv
// Splits one flash op into cmd/addr/dummy/data byte requests; first byte the cycle after accept, one idle cycle between bytes.
// Program data waits on wdata_valid; read data has no backpressure. QSPI_SEQ_QUAD_EN enables the x4 QUAD_READ path.
module qspi_flash_sequencer
    import qspi_pkg::*;
#(
    parameter int ADDR_BYTES  = 3,
    parameter int DUMMY_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    qspi_flash_sequencer_if.master bus
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_BYTES - 1);

    state_e      state_q, state_d;
    state_e      phase_q, phase_d;
    op_e         op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_tx_q, byte_tx_d;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_r_w_q, byte_r_w_d;
    logic [1:0]  byte_width_q, byte_width_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;

    op_e         req_op_eff;
    logic        is_quad;
    logic [1:0]  data_width;
    logic [8:0]  page_sum;
    logic [31:0] addr_ext;
    logic [7:0]  addr_byte;
    logic        xfer;
    logic        load_wdata;

`ifdef QSPI_SEQ_QUAD_EN
    assign req_op_eff = op_e'(bus.req_op);
    assign is_quad    = (op_q == OP_QUAD_READ);
    assign data_width = is_quad ? WIREWIDTH_4 : WIREWIDTH_1;
`else
    // Without quad support op 01 degrades to a plain single-wire READ.
    assign req_op_eff = (op_e'(bus.req_op) == OP_QUAD_READ) ? OP_READ : op_e'(bus.req_op);
    assign is_quad    = 1'b0;
    assign data_width = WIREWIDTH_1;
`endif

    assign page_sum   = {1'b0, bus.req_addr[7:0]} + {1'b0, bus.req_len};
    assign addr_ext   = {8'h00, addr_q};
    assign addr_byte  = addr_ext[{cnt_q[1:0], 3'b000} +: 8];
    assign xfer       = byte_valid_q && bus.byte_ready;
    assign load_wdata = (state_q == ST_DATA) && (op_q == OP_PAGE_PROG) && !byte_valid_q && bus.wdata_valid;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        op_d          = op_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        byte_tx_d     = byte_tx_q;
        byte_valid_d  = byte_valid_q;
        byte_r_w_d    = byte_r_w_q;
        byte_width_d  = byte_width_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (req_op_eff == OP_PAGE_PROG && page_sum[8]) begin
                        err_d = 1'b1;
                    end else begin
                        op_d         = req_op_eff;
                        addr_d       = bus.req_addr;
                        len_d        = bus.req_len;
                        cnt_d        = 8'd0;
                        state_d      = ST_CMD;
                        byte_valid_d = 1'b1;
                        byte_tx_d    = op_opcode(req_op_eff);
                        byte_r_w_d   = 1'b1;
                        byte_width_d = WIREWIDTH_1;
                    end
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (load_wdata) begin
                    byte_valid_d = 1'b1;
                    byte_tx_d    = bus.wdata;
                    byte_r_w_d   = 1'b1;
                    byte_width_d = WIREWIDTH_1;
                end
                if (xfer) begin
                    byte_valid_d = 1'b0;
                    state_d      = ST_GAP;
                    if (state_q == ST_DATA && op_q != OP_PAGE_PROG) begin
                        rdata_d       = bus.byte_rx;
                        rdata_valid_d = 1'b1;
                    end
                    if (cnt_q != 8'd0) begin
                        cnt_d   = cnt_q - 8'd1;
                        phase_d = state_q;
                    end else begin
                        case (state_q)
                            ST_CMD: begin
                                if (op_q == OP_WREN) begin
                                    phase_d = ST_DONE;
                                end else begin
                                    phase_d = ST_ADDR;
                                    cnt_d   = ADDR_LAST;
                                end
                            end
                            ST_ADDR: begin
                                if (is_quad) begin
                                    phase_d = ST_DUMMY;
                                    cnt_d   = DUMMY_LAST;
                                end else begin
                                    phase_d = ST_DATA;
                                    cnt_d   = len_q;
                                end
                            end
                            ST_DUMMY: begin
                                phase_d = ST_DATA;
                                cnt_d   = len_q;
                            end
                            default: phase_d = ST_DONE;
                        endcase
                    end
                end
            end
            // One idle cycle so the controller can drop its completion flag.
            ST_GAP: begin
                state_d = phase_q;
                case (phase_q)
                    ST_ADDR: begin
                        byte_valid_d = 1'b1;
                        byte_tx_d    = addr_byte;
                        byte_r_w_d   = 1'b1;
                        byte_width_d = WIREWIDTH_1;
                    end
`ifdef QSPI_SEQ_QUAD_EN
                    ST_DUMMY: begin
                        byte_valid_d = 1'b1;
                        byte_tx_d    = 8'h00;
                        byte_r_w_d   = 1'b1;
                        byte_width_d = WIREWIDTH_1;
                    end
`endif
                    ST_DATA: begin
                        if (op_q != OP_PAGE_PROG) begin
                            byte_valid_d = 1'b1;
                            byte_tx_d    = 8'h00;
                            byte_r_w_d   = 1'b0;
                            byte_width_d = data_width;
                        end
                    end
                    ST_DONE: done_d = 1'b1;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= ST_IDLE;
            op_q          <= OP_READ;
            addr_q        <= 24'h0;
            len_q         <= 8'h0;
            cnt_q         <= 8'h0;
            byte_tx_q     <= 8'h0;
            byte_valid_q  <= 1'b0;
            byte_r_w_q    <= 1'b0;
            byte_width_q  <= WIREWIDTH_1;
            rdata_q       <= 8'h0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            byte_tx_q     <= byte_tx_d;
            byte_valid_q  <= byte_valid_d;
            byte_r_w_q    <= byte_r_w_d;
            byte_width_q  <= byte_width_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.wdata_ready = load_wdata;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.byte_tx     = byte_tx_q;
    assign bus.byte_r_w    = byte_r_w_q;
    assign bus.byte_width  = byte_width_q;
    assign bus.byte_valid  = byte_valid_q;

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Directed bench for qspi_flash_sequencer: models the byte controller, the write-data source
// and a read-data scoreboard, and checks each flash operation against hand-derived byte sequences.
module tb_qspi_flash_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_flash_sequencer_if bus();

    qspi_flash_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int comp_cyc = 0;
    int n_rvld = 0;
    int n_wrdy = 0;
    int n_done = 0;
    int n_err  = 0;

    logic [7:0] tx_log[$];
    logic       rw_log[$];
    logic [1:0] wd_log[$];
    logic [7:0] rexp[$];
    logic [7:0] rx_next;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte controller: completes each byte two cycles after byte_valid rises.
    initial begin
        int wc;
        wc = 0;
        bus.byte_ready = 1'b0;
        bus.byte_rx    = 8'h00;
        rx_next        = 8'hA5;
        forever begin
            @(posedge clk);
            #2;
            if (bus.byte_ready) begin
                bus.byte_ready = 1'b0;
                wc = 0;
            end else if (bus.byte_valid) begin
                wc++;
                if (wc == 2) begin
                    tx_log.push_back(bus.byte_tx);
                    rw_log.push_back(bus.byte_r_w);
                    wd_log.push_back(bus.byte_width);
                    if (!bus.byte_r_w) begin
                        bus.byte_rx = rx_next;
                        rexp.push_back(rx_next);
                        rx_next = rx_next + 8'h1D;
                    end
                    bus.byte_ready = 1'b1;
                    comp_cyc = cyc;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Write-data source: advances to the next byte after each consume.
    initial begin
        bus.wdata = 8'h40;
        forever begin
            @(negedge clk);
            if (bus.wdata_ready) begin
                n_wrdy++;
                @(posedge clk);
                #1;
                bus.wdata = bus.wdata + 8'h01;
            end
        end
    end

    // Output monitor and read-data scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.rdata_valid) begin
                n_rvld++;
                if (rexp.size() != 0) chk("rdata", bus.rdata, rexp.pop_front());
            end
            if (bus.done) n_done++;
            if (bus.err)  n_err++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        tx_log.delete();
        rw_log.delete();
        wd_log.delete();
        rexp.delete();
        n_rvld = 0;
        n_wrdy = 0;
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [7:0] l);
        for (int k = 0; k < 50 && !bus.req_ready; k++) step(1);
        chk("req_ready_before_issue", bus.req_ready, 1'b1);
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_valid = 1'b1;
        step(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 2000 && !bus.done; k++) step(1);
        chk({tag, "_done"}, bus.done, 1'b1);
        if (bus.done) chk({tag, "_done_lat"}, cyc - comp_cyc, 2);
        step(2);
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [7:0] tx,
                            input logic rw, input logic [1:0] w);
        chk({tag, "_present"}, tx_log.size() > i, 1'b1);
        if (tx_log.size() > i) begin
            chk({tag, "_tx"}, tx_log[i], tx);
            chk({tag, "_rw"}, rw_log[i], rw);
            chk({tag, "_w"},  wd_log[i], w);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = 2'b00;
        bus.req_addr    = 24'h0;
        bus.req_len     = 8'h0;
        bus.wdata_valid = 1'b0;

        step(2);
        chk("rst_req_ready",  bus.req_ready,   1'b0);
        chk("rst_byte_valid", bus.byte_valid,  1'b0);
        chk("rst_byte_tx",    bus.byte_tx,     8'h00);
        chk("rst_byte_r_w",   bus.byte_r_w,    1'b0);
        chk("rst_byte_width", bus.byte_width,  2'b00);
        chk("rst_busy",       bus.busy,        1'b0);
        chk("rst_wdata_rdy",  bus.wdata_ready, 1'b0);
        chk("rst_rdata",      bus.rdata,       8'h00);
        chk("rst_rvld",       bus.rdata_valid, 1'b0);
        chk("rst_done",       bus.done,        1'b0);
        chk("rst_err",        bus.err,         1'b0);
        rst = 1'b0;
        step(1);
        chk("post_rst_req_ready", bus.req_ready, 1'b1);

        // WREN: single opcode byte then done.
        clr();
        issue(2'b11, 24'h0, 8'h0);
        chk("wren_first_valid", bus.byte_valid, 1'b1);
        chk("wren_first_tx",    bus.byte_tx,    8'h06);
        chk("wren_busy",        bus.busy,       1'b1);
        chk("wren_req_ready",   bus.req_ready,  1'b0);
        wait_done("wren");
        chk("wren_nbytes", tx_log.size(), 1);
        chk_byte("wren_b0", 0, 8'h06, 1'b1, 2'b00);
        chk("wren_rvld", n_rvld, 0);
        chk("wren_wrdy", n_wrdy, 0);
        chk("wren_ndone", n_done, 1);

        // READ 0x123456, 4 bytes.
        clr();
        issue(2'b00, 24'h123456, 8'd3);
        chk("read_first_tx", bus.byte_tx, 8'h03);
        wait_done("read");
        chk("read_nbytes", tx_log.size(), 8);
        chk_byte("read_cmd", 0, 8'h03, 1'b1, 2'b00);
        chk_byte("read_a0",  1, 8'h12, 1'b1, 2'b00);
        chk_byte("read_a1",  2, 8'h34, 1'b1, 2'b00);
        chk_byte("read_a2",  3, 8'h56, 1'b1, 2'b00);
        for (int i = 4; i < 8; i++) chk_byte("read_d", i, 8'h00, 1'b0, 2'b00);
        chk("read_rvld", n_rvld, 4);
        chk("read_rexp_left", rexp.size(), 0);

        // QUAD_READ 0x0A0B0C, 1 byte.
        clr();
        issue(2'b01, 24'h0A0B0C, 8'd0);
`ifdef QSPI_SEQ_QUAD_EN
        chk("qread_first_tx", bus.byte_tx, 8'h6B);
        wait_done("qread");
        chk("qread_nbytes", tx_log.size(), 6);
        chk_byte("qread_cmd",   0, 8'h6B, 1'b1, 2'b00);
        chk_byte("qread_a0",    1, 8'h0A, 1'b1, 2'b00);
        chk_byte("qread_a1",    2, 8'h0B, 1'b1, 2'b00);
        chk_byte("qread_a2",    3, 8'h0C, 1'b1, 2'b00);
        chk_byte("qread_dummy", 4, 8'h00, 1'b1, 2'b00);
        chk_byte("qread_d0",    5, 8'h00, 1'b0, 2'b11);
`else
        chk("qread_first_tx", bus.byte_tx, 8'h03);
        wait_done("qread");
        chk("qread_nbytes", tx_log.size(), 5);
        chk_byte("qread_cmd", 0, 8'h03, 1'b1, 2'b00);
        chk_byte("qread_a0",  1, 8'h0A, 1'b1, 2'b00);
        chk_byte("qread_a1",  2, 8'h0B, 1'b1, 2'b00);
        chk_byte("qread_a2",  3, 8'h0C, 1'b1, 2'b00);
        chk_byte("qread_d0",  4, 8'h00, 1'b0, 2'b00);
`endif
        chk("qread_rvld", n_rvld, 1);

        // PAGE_PROG 0xF0 + 16 bytes ends exactly at the page boundary; data stalled.
        clr();
        issue(2'b10, 24'h0000F0, 8'd15);
        chk("prog_first_tx", bus.byte_tx, 8'h02);
        step(20);
        chk("prog_stall_nbytes", tx_log.size(), 4);
        chk("prog_stall_valid",  bus.byte_valid, 1'b0);
        chk("prog_stall_wrdy",   n_wrdy, 0);
        chk("prog_stall_busy",   bus.busy, 1'b1);
        bus.wdata_valid = 1'b1;
        wait_done("prog");
        bus.wdata_valid = 1'b0;
        chk("prog_wrdy", n_wrdy, 16);
        chk("prog_nbytes", tx_log.size(), 20);
        chk_byte("prog_a2", 3, 8'hF0, 1'b1, 2'b00);
        for (int i = 0; i < 16; i++) chk_byte("prog_d", 4 + i, 8'h40 + 8'(i), 1'b1, 2'b00);
        chk("prog_rvld", n_rvld, 0);

        // PAGE_PROG crossing the page: rejected.
        clr();
        issue(2'b10, 24'h0000F0, 8'd16);
        chk("cross_err",        bus.err,        1'b1);
        chk("cross_req_ready",  bus.req_ready,  1'b1);
        chk("cross_byte_valid", bus.byte_valid, 1'b0);
        chk("cross_busy",       bus.busy,       1'b0);
        step(5);
        chk("cross_nbytes", tx_log.size(), 0);
        chk("cross_nerr",   n_err, 1);

        // Reset during the address phase, then a clean READ.
        clr();
        issue(2'b00, 24'h654321, 8'd1);
        step(4);
        chk("mid_in_addr_valid", bus.byte_valid, 1'b1);
        chk("mid_in_addr_tx",    bus.byte_tx,    8'h65);
        rst = 1'b1;
        step(1);
        chk("mid_rst_byte_valid", bus.byte_valid, 1'b0);
        chk("mid_rst_busy",       bus.busy,       1'b0);
        chk("mid_rst_req_ready",  bus.req_ready,  1'b0);
        chk("mid_rst_rdata",      bus.rdata,      8'h00);
        chk("mid_rst_byte_tx",    bus.byte_tx,    8'h00);
        rst = 1'b0;
        step(2);
        chk("mid_rst_idle_valid", bus.byte_valid, 1'b0);
        clr();
        issue(2'b00, 24'h000010, 8'd1);
        wait_done("after_rst");
        chk("after_rst_nbytes", tx_log.size(), 6);
        chk_byte("after_rst_cmd", 0, 8'h03, 1'b1, 2'b00);
        chk_byte("after_rst_a2",  3, 8'h10, 1'b1, 2'b00);
        chk("after_rst_rvld", n_rvld, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
